// File: rtl/serial_pkg.sv
// Shared definitions for the serializer slice: FSM state encoding and a
// counter-width helper that never returns less than one bit.
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bits needed to count 0..n-1, never less than 1.
  function automatic int unsigned clog2_min1(input int unsigned n);
    if (n <= 1) return 1;
    return 32'($clog2(n));
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word handshake between an upstream producer and the serializer.
//   data_in  : parallel word, sampled only on accept
//   in_valid : producer has a word
//   in_ready : serializer can accept this cycle
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] data_in;
  logic             in_valid;
  logic             in_ready;

  modport master (output data_in, output in_valid, input in_ready);
  modport slave  (input data_in, input in_valid, output in_ready);

endinterface

// File: rtl/bit_tick_gen.sv
// Modulo-DIV period counter for the serial bit clock.
//   clk, rst : clock and synchronous active-high reset
//   run      : counter advances while high, clears while low
//   tick     : high in the last cycle of each DIV-cycle period
module bit_tick_gen
  import serial_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int unsigned     CNT_W = clog2_min1(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  // Wraps at LAST so the counter never exceeds its terminal value.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  assign tick = run && (div_cnt == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage feeding an enabled D flop.
//   clk, rst : clock and synchronous active-high reset
//   up       : word handshake (data_in, in_valid, in_ready)
//   ser_out  : current serial bit (downstream din)
//   ser_en   : one-cycle strobe in the last cycle of each bit (downstream en)
//   busy     : high while shifting
//   done     : one-cycle pulse after the last bit's strobe
module piso_serializer
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIV       = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  piso_serializer_if.slave         up,
  output logic                     ser_out,
  output logic                     ser_en,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned      BIT_W    = clog2_min1(WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [BIT_W-1:0] bit_cnt;

  logic             accept;
  logic             last_strobe;
  logic             run;
  logic             tick;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] sreg_shifted;

  assign up.in_ready = !rst && (state == IDLE);
  assign accept      = up.in_valid && up.in_ready;
  assign last_strobe = (state == SHIFT) && ser_en && (bit_cnt == LAST_BIT);

  // The period counter starts on the accept cycle so that its tick lands one
  // cycle before each strobe; registering tick then yields ser_en exactly in
  // the last cycle of every bit.
  assign run = !rst && (accept || ((state == SHIFT) && !last_strobe));

  bit_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .tick (tick)
  );

  // Shift direction and the bit that becomes visible after each strobe.
  always_comb begin
    sreg_shifted = sreg;
    next_bit     = 1'b0;
    first_bit    = 1'b0;
    if (MSB_FIRST) begin
      sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
      next_bit     = sreg[WIDTH-2];
      first_bit    = up.data_in[WIDTH-1];
    end else begin
      sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
      next_bit     = sreg[1];
      first_bit    = up.data_in[0];
    end
  end

  // FSM, shift register, bit counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
      ser_out <= 1'b0;
      ser_en  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      ser_en <= tick;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            sreg    <= up.data_in;
            bit_cnt <= '0;
            ser_out <= first_bit;
            busy    <= 1'b1;
            state   <= SHIFT;
          end else begin
            ser_out <= 1'b0;
          end
        end
        SHIFT: begin
          if (ser_en) begin
            if (bit_cnt == LAST_BIT) begin
              state   <= IDLE;
              busy    <= 1'b0;
              ser_out <= 1'b0;
              done    <= 1'b1;
            end else begin
              sreg    <= sreg_shifted;
              ser_out <= next_bit;
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: three instances (MSB-first DIV=4,
// LSB-first DIV=4, MSB-first DIV=1) share clk/rst; sel routes the stimulus
// to one instance at a time. A downstream enabled flop per instance captures
// ser_out on ser_en.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  int         sel;
  logic       tb_valid;
  logic [7:0] tb_data;

  logic [2:0] so, en, bz, dn, rdy, q;

  int checks = 0;
  int errors = 0;

  piso_serializer_if #(.WIDTH(8)) if_msb ();
  piso_serializer_if #(.WIDTH(8)) if_lsb ();
  piso_serializer_if #(.WIDTH(8)) if_d1 ();

  assign if_msb.in_valid = tb_valid && (sel == 0);
  assign if_lsb.in_valid = tb_valid && (sel == 1);
  assign if_d1.in_valid  = tb_valid && (sel == 2);
  assign if_msb.data_in  = tb_data;
  assign if_lsb.data_in  = tb_data;
  assign if_d1.data_in   = tb_data;
  assign rdy = {if_d1.in_ready, if_lsb.in_ready, if_msb.in_ready};

  piso_serializer #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b1)) u_msb (
    .clk (clk), .rst (rst), .up (if_msb),
    .ser_out (so[0]), .ser_en (en[0]), .busy (bz[0]), .done (dn[0])
  );

  piso_serializer #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk (clk), .rst (rst), .up (if_lsb),
    .ser_out (so[1]), .ser_en (en[1]), .busy (bz[1]), .done (dn[1])
  );

  piso_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b1)) u_d1 (
    .clk (clk), .rst (rst), .up (if_d1),
    .ser_out (so[2]), .ser_en (en[2]), .busy (bz[2]), .done (dn[2])
  );

  // Downstream enabled D flops.
  always @(posedge clk) begin
    q <= (en & so) | (~en & q);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called in cycle 0 (just after an edge); presents data and follows the
  // frame to its done cycle 8*div+1, where it returns. seq holds the
  // expected serial order, seq[7] first. With hold set, in_valid stays high
  // with hold_data from cycle 1 on.
  task automatic send_frame(input string name, input int div, input logic [7:0] data,
                            input logic [7:0] seq, input bit hold, input logic [7:0] hold_data);
    int last;
    last = 8 * div;
    tb_data  = data;
    tb_valid = 1'b1;
    #1;
    check($sformatf("%s ready c0", name), 32'(rdy[sel]), 32'd1);
    for (int c = 1; c <= last + 1; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        if (hold) tb_data = hold_data;
        else tb_valid = 1'b0;
      end
      check($sformatf("%s ser_out c%0d", name, c), 32'(so[sel]),
            (c <= last) ? 32'(seq[7 - (c - 1) / div]) : 32'd0);
      check($sformatf("%s ser_en c%0d", name, c), 32'(en[sel]),
            ((c % div == 0) && (c <= last)) ? 32'd1 : 32'd0);
      check($sformatf("%s busy c%0d", name, c), 32'(bz[sel]), (c <= last) ? 32'd1 : 32'd0);
      check($sformatf("%s done c%0d", name, c), 32'(dn[sel]), (c == last + 1) ? 32'd1 : 32'd0);
      check($sformatf("%s ready c%0d", name, c), 32'(rdy[sel]), (c == last + 1) ? 32'd1 : 32'd0);
      if (c > div)
        check($sformatf("%s q c%0d", name, c), 32'(q[sel]), 32'(seq[8 - (c - 1) / div]));
    end
  endtask

  initial begin
    rst      = 1'b1;
    sel      = 0;
    tb_valid = 1'b0;
    tb_data  = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("reset outs", 32'({so, en, bz, dn}), 32'd0);
    check("reset ready", 32'(rdy), 32'd0);
    rst = 1'b0;

    // Idle with in_valid low: nothing moves, all instances ready.
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("idle c%0d", c), 32'({bz, en, dn, rdy}), 32'h007);
    end

    // MSB first 0xC1 with 0x5A pending during SHIFT, then 0x5A itself.
    sel = 0;
    send_frame("msb_c1", 4, 8'hC1, 8'hC1, 1'b1, 8'h5A);
    send_frame("msb_5a", 4, 8'h5A, 8'h5A, 1'b0, 8'h00);

    // LSB first 0xC1: serial order 1,0,0,0,0,0,1,1.
    sel = 1;
    send_frame("lsb_c1", 4, 8'hC1, 8'h83, 1'b0, 8'h00);

    // DIV=1 back to back 0xFF then 0x00, in_valid held high.
    sel = 2;
    send_frame("d1_ff", 1, 8'hFF, 8'hFF, 1'b1, 8'h00);
    send_frame("d1_00", 1, 8'h00, 8'h00, 1'b0, 8'h00);

    // Reset in cycle 10 of a DIV=4 frame.
    sel      = 0;
    tb_data  = 8'hC1;
    tb_valid = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) tb_valid = 1'b0;
    end
    check("rst busy c10", 32'(bz[0]), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst c11 outs", 32'({so[0], en[0], bz[0], dn[0]}), 32'd0);
    check("rst c11 ready", 32'(rdy[0]), 32'd0);
    rst = 1'b0;
    #1;
    check("rst fall ready", 32'(rdy[0]), 32'd1);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("post rst c%0d", c), 32'({bz[0], en[0], dn[0], rdy[0]}), 32'h1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out stage that sits directly upstream of the enabled D flip-flop stage. It accepts a WIDTH-bit word over a valid/ready handshake and presents it one bit at a time on `ser_out`. It drives `ser_en` once per bit so the downstream flop (`din` ← `ser_out`, `en` ← `ser_en`) captures each bit exactly once, and it pulses `done` when the word has been fully shifted.

## Interface
- `WIDTH`, 8: word width; legal values ≥ 2.
- `DIV`, 4: clock cycles per serial bit; legal values ≥ 1.
- `MSB_FIRST`, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data_in`  in  WIDTH  parallel word; sampled only on accept.
- `in_valid`  in  1  upstream has a word.
- `in_ready`  out  1  block can accept; high only in IDLE and while `rst`=0.
- `ser_out`  out  1  current serial bit; drives downstream `din`.
- `ser_en`  out  1  one-cycle strobe per bit; drives downstream `en`.
- `busy`  out  1  high while in SHIFT.
- `done`  out  1  one-cycle pulse after the last bit's strobe.

## Operation
- Reset values: state IDLE, `ser_out`=0, `ser_en`=0, `busy`=0, `done`=0, `in_ready`=0 while `rst`=1.
- Accept: occurs when `in_valid && in_ready` is high at a rising edge.
  - Load the shift register with `data_in`; clear `div_cnt` and `bit_cnt`; go to SHIFT.
- States:
  - IDLE: `ser_out` is held at 0.
  - SHIFT: `div_cnt` counts 0..DIV-1.
    - At `div_cnt`=DIV-1: `ser_en`=1, `div_cnt` wraps to 0, the shift register advances, and `bit_cnt` increments.
    - When the strobe is for `bit_cnt`=WIDTH-1: return to IDLE and set `done` for the following cycle.
- `ser_out`, `ser_en`, `busy` and `done` are all registered outputs.
- Shift direction is set by `MSB_FIRST`. The shift register fills with 0.
- `in_valid` and `data_in` are ignored outside accept; words are not queued or buffered.
- DIV=1: `ser_en` is high every SHIFT cycle.
- Counter widths: `div_cnt` is max(1, clog2(DIV)) bits; `bit_cnt` is max(1, clog2(WIDTH)) bits. Neither counter may exceed its terminal value.
- Reset mid-frame: abort. The next cycle shows reset values, with no `done` and no further `ser_en`. The partial word is discarded.

## Timing
Cycle 0 is the accept cycle.
- Bit k is on `ser_out` in cycles k·DIV+1 .. (k+1)·DIV.
- `ser_en` is high in cycle (k+1)·DIV, the last cycle of bit k. The downstream flop's `q` shows bit k from cycle (k+1)·DIV+1.
- `busy` is high in cycles 1..WIDTH·DIV.
- `done` and `in_ready` are high in cycle WIDTH·DIV+1. A new accept is possible that cycle.
- Throughput: one word per WIDTH·DIV+1 cycles with `in_valid` held high.
- No combinational path from inputs to outputs, except `in_ready` depending on `rst`.

## Structure
- Shared package `serial_pkg`:
  - state encoding `IDLE`=1'b0, `SHIFT`=1'b1;
  - a clog2 helper returning ≥ 1.
- Sub-module `bit_tick_gen` (parameter DIV; ports `clk`, `rst`, `run`, `tick`): a modulo-DIV counter. `tick` is high in the last cycle of each period and the counter clears while `run`=0. The `piso_serializer` FSM, shift register and `bit_cnt` consume `tick`.

## Test plan
- WIDTH=8, DIV=4, MSB_FIRST=1, accept 0xC1 in cycle 0:
  - `ser_out` = 1,1,0,0,0,0,0,1, each bit held 4 cycles;
  - `ser_en` high exactly in cycles 4,8,…,32;
  - `done` high in cycle 33 only;
  - downstream `q` sequence matches.
- Same setup with MSB_FIRST=0 and 0xC1: `ser_out` = 1,0,0,0,0,0,1,1.
- DIV=1, `in_valid` held high with 0xFF then 0x00:
  - `ser_en` high in cycles 1–8;
  - second accept in cycle 9;
  - `ser_out` is 0 in cycles 10–17;
  - `done` in cycles 9 and 18.
- During SHIFT of 0xC1, present `in_valid`=1 with 0x5A:
  - `in_ready`=0 throughout;
  - serial output is unchanged 0xC1;
  - 0x5A is accepted only in cycle 33 if still valid.
- `rst` high in cycle 10 of a DIV=4 frame:
  - cycle 11: `ser_out`/`ser_en`/`busy`/`done`=0;
  - no later `done`;
  - `in_ready`=1 in the first cycle after `rst` falls.
- `in_valid` held 0 for 50 cycles after reset: `busy`, `ser_en` and `done` stay 0 and `in_ready` stays 1.
